// File: rtl/deser400_tp_pkg.sv
// rtl/deser400_tp_pkg.sv - shared state and trigger-select encodings for the deser400 test-point capture
package deser400_tp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        READ = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [1:0] TRIG_RISE_A = 2'd0;
    localparam logic [1:0] TRIG_FALL_A = 2'd1;
    localparam logic [1:0] TRIG_RISE_B = 2'd2;
    localparam logic [1:0] TRIG_FALL_B = 2'd3;

endpackage

// File: rtl/tp_capture_ram.sv
// rtl/tp_capture_ram.sv - simple dual-port DEPTH x 2 sample store, sync write, registered read
module tp_capture_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/deser400_tp_capture.sv
// rtl/deser400_tp_capture.sv - edge-triggered tpa/tpb capture with pre-trigger and valid/ready readout; optional force_trig via DESER400_TP_CAPTURE_FORCE_EN
module deser400_tp_capture
    import deser400_tp_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int PRETRIG = 16,
    parameter int AW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic [1:0] trig_sel,
    input  logic       tpa,
    input  logic       tpb,
`ifdef DESER400_TP_CAPTURE_FORCE_EN
    input  logic       force_trig,
`endif
    output logic       busy,
    output logic       done,
    output logic [1:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       rd_last
);

    localparam int CW = AW + 1;

    state_t          state, state_next;
    logic [1:0]      s, prev, tsel;
    logic [AW-1:0]   wp, tp, ra;
    logic [CW-1:0]   cnt, rcnt;
    logic            arm_go, we, trig, edge_hit, ren, last_q;
    logic [1:0]      ram_q;

    assign arm_go = arm && (state == IDLE || state == DONE);

    // prev is aligned to s on arm so the first captured sample can never look like an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s    <= 2'b00;
            prev <= 2'b00;
        end else begin
            s    <= {tpb, tpa};
            prev <= arm_go ? {tpb, tpa} : s;
        end
    end

    always_comb begin
        edge_hit = 1'b0;
        case (tsel)
            TRIG_RISE_A: edge_hit = !prev[0] &&  s[0];
            TRIG_FALL_A: edge_hit =  prev[0] && !s[0];
            TRIG_RISE_B: edge_hit = !prev[1] &&  s[1];
            TRIG_FALL_B: edge_hit =  prev[1] && !s[1];
            default:     edge_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        we         = 1'b0;
        trig       = 1'b0;
        case (state)
            IDLE, DONE: if (arm) state_next = PRE;
            PRE: begin
                we = 1'b1;
                if (cnt == CW'(PRETRIG - 1)) state_next = WAIT;
            end
            WAIT: begin
                we = 1'b1;
`ifdef DESER400_TP_CAPTURE_FORCE_EN
                trig = edge_hit || force_trig;
`else
                trig = edge_hit;
`endif
                if (trig) state_next = POST;
            end
            POST: begin
                we = 1'b1;
                if (cnt == CW'(DEPTH - PRETRIG - 1)) state_next = READ;
            end
            READ: if (rd_valid && rd_ready && last_q) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Reads are only issued when the output slot is empty or being drained, so the RAM
    // output register doubles as the holding register during a stall.
    assign ren = (state == READ) && (rcnt != CW'(DEPTH)) && (!rd_valid || rd_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tsel     <= 2'b00;
            wp       <= '0;
            tp       <= '0;
            ra       <= '0;
            cnt      <= '0;
            rcnt     <= '0;
            rd_valid <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            if (arm_go) begin
                tsel <= trig_sel;
                wp   <= '0;
                cnt  <= '0;
            end
            if (we) begin
                wp  <= wp + 1'b1;
                cnt <= trig ? CW'(1) : cnt + 1'b1;
                if (trig) tp <= wp;
            end
            if (state == POST && state_next == READ) begin
                ra   <= tp - AW'(PRETRIG);
                rcnt <= '0;
            end
            if (ren) begin
                ra       <= ra + 1'b1;
                rcnt     <= rcnt + 1'b1;
                last_q   <= (rcnt == CW'(DEPTH - 1));
                rd_valid <= 1'b1;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

    tp_capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wp),
        .wdata (s),
        .re    (ren),
        .raddr (ra),
        .rdata (ram_q)
    );

    assign rd_data = rd_valid ? ram_q : 2'b00;
    assign rd_last = rd_valid && last_q;
    assign busy    = (state == PRE) || (state == WAIT) || (state == POST) || (state == READ);
    assign done    = (state == DONE);

endmodule
